// File: rtl/pwm_multi_channel.sv
// rtl/pwm_multi_channel.sv - multi-channel PWM with shared prescaler and period counter
// Optional feature macro: PWM_CENTER_ALIGNED_EN (adds the center input, up/down counting).
// Ports:
//   clk, rst         single clock, synchronous active-high reset
//   en_out, en_pwm   per-channel output enable / PWM mode (0 = static high)
//   period           counter top value, latched at each wrap
//   prescale         tick every prescale+1 clk cycles, applied immediately
//   duty_wr/ch/val   one-cycle write of a channel's duty shadow register
//   center           (macro only) center-aligned mode, sampled at wrap
//   out              registered channel outputs
//   period_tick      one-cycle pulse in the cycle after each wrap
module pwm_multi_channel #(
  parameter int NUM_CH  = 16,
  parameter int CNT_W   = 8,
  parameter int PRESC_W = 8,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_CH-1:0]  en_out,
  input  logic [NUM_CH-1:0]  en_pwm,
  input  logic [CNT_W-1:0]   period,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               duty_wr,
  input  logic [CH_W-1:0]    duty_ch,
  input  logic [CNT_W-1:0]   duty_val,
`ifdef PWM_CENTER_ALIGNED_EN
  input  logic               center,
`endif
  output logic [NUM_CH-1:0]  out,
  output logic               period_tick
);

  logic [PRESC_W-1:0] psc;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [CNT_W-1:0]   per_act;
  logic [CNT_W-1:0]   shadow [NUM_CH];
  logic [CNT_W-1:0]   active [NUM_CH];
  logic [NUM_CH-1:0]  wr_hit;
  logic               tick;
  logic               at_wrap;
  logic               wrap;

  assign tick = (psc == prescale);
  assign wrap = tick & at_wrap;

  // >= also catches psc left above a freshly lowered prescale: back to 0, no tick.
  always_ff @(posedge clk) begin
    if (rst)                 psc <= '0;
    else if (psc >= prescale) psc <= '0;
    else                     psc <= psc + 1'b1;
  end

`ifdef PWM_CENTER_ALIGNED_EN
  logic center_act;
  logic down;
  logic down_nxt;

  // Direction state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      center_act <= 1'b0;
      down       <= 1'b0;
    end else if (tick) begin
      down <= down_nxt;
      if (at_wrap) center_act <= center;
    end
  end

  // Next count / direction. In center mode the wrap is the step that lands on 0
  // while descending; per_act<=1 degenerates to a wrap straight from the top.
  always_comb begin
    cnt_nxt  = cnt;
    down_nxt = down;
    at_wrap  = 1'b0;
    if (!center_act) begin
      if (cnt == per_act) begin
        at_wrap = 1'b1;
        cnt_nxt = '0;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end else if (!down) begin
      if (cnt == per_act) begin
        if (per_act <= CNT_W'(1)) begin
          at_wrap = 1'b1;
          cnt_nxt = '0;
        end else begin
          cnt_nxt  = cnt - 1'b1;
          down_nxt = 1'b1;
        end
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end else begin
      if (cnt <= CNT_W'(1)) begin
        at_wrap  = 1'b1;
        cnt_nxt  = '0;
        down_nxt = 1'b0;
      end else begin
        cnt_nxt = cnt - 1'b1;
      end
    end
  end
`else
  always_comb begin
    at_wrap = (cnt == per_act);
    cnt_nxt = at_wrap ? '0 : cnt + 1'b1;
  end
`endif

  // After reset cnt==per_act==0, so the first tick is a wrap and loads period.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      per_act     <= '0;
      period_tick <= 1'b0;
    end else begin
      period_tick <= wrap;
      if (tick) cnt     <= cnt_nxt;
      if (wrap) per_act <= period;
    end
  end

  // Out-of-range duty_ch never matches any index, so such writes are dropped.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NUM_CH; i++) wr_hit[i] = duty_wr && (duty_ch == CH_W'(i));
  end

  // A write coinciding with a wrap is forwarded straight into active.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end else begin
        if (wr_hit[i]) shadow[i] <= duty_val;
        if (wrap)      active[i] <= wr_hit[i] ? duty_val : shadow[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        out[i] <= en_out[i] & (~en_pwm[i] | (cnt < active[i]));
    end
  end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// tb/tb_pwm_multi_channel.sv - self-checking bench for pwm_multi_channel
module tb_pwm_multi_channel;

  localparam int NCH = 12;
  localparam int CW  = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] en_out = '0;
  logic [NCH-1:0] en_pwm = '0;
  logic [7:0]     period = '0;
  logic [7:0]     prescale = '0;
  logic           duty_wr = 1'b0;
  logic [CW-1:0]  duty_ch = '0;
  logic [7:0]     duty_val = '0;
`ifdef PWM_CENTER_ALIGNED_EN
  logic           center = 1'b0;
`endif
  logic [NCH-1:0] out;
  logic           period_tick;

  pwm_multi_channel #(.NUM_CH(NCH), .CNT_W(8), .PRESC_W(8)) dut (
    .clk(clk), .rst(rst), .en_out(en_out), .en_pwm(en_pwm),
    .period(period), .prescale(prescale), .duty_wr(duty_wr),
    .duty_ch(duty_ch), .duty_val(duty_val),
`ifdef PWM_CENTER_ALIGNED_EN
    .center(center),
`endif
    .out(out), .period_tick(period_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: plain integers following the behavioural rules.
  int             psc_m, cnt_m, per_m;
  int             sh_m [NCH];
  int             act_m [NCH];
  logic [NCH-1:0] out_exp;
  logic           ptick_exp;
  int             hi [NCH];
  int             nt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [NCH-1:0] nout;
    bit tick_m, wrap_m;
    if (rst) begin
      psc_m = 0; cnt_m = 0; per_m = 0;
      for (int i = 0; i < NCH; i++) begin sh_m[i] = 0; act_m[i] = 0; end
      out_exp = '0; ptick_exp = 1'b0;
      return;
    end
    for (int i = 0; i < NCH; i++)
      nout[i] = en_out[i] && (!en_pwm[i] || (cnt_m < act_m[i]));
    tick_m = (psc_m == int'(prescale));
    wrap_m = tick_m && (cnt_m == per_m);
    psc_m  = (psc_m >= int'(prescale)) ? 0 : psc_m + 1;
    if (tick_m) cnt_m = wrap_m ? 0 : cnt_m + 1;
    if (duty_wr && int'(duty_ch) < NCH) sh_m[duty_ch] = int'(duty_val);
    if (wrap_m) begin
      per_m = int'(period);
      for (int i = 0; i < NCH; i++) act_m[i] = sh_m[i];
    end
    out_exp   = nout;
    ptick_exp = wrap_m;
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("out", 32'(out), 32'(out_exp));
    chk("period_tick", 32'(period_tick), 32'(ptick_exp));
  endtask

  task automatic clear_win();
    for (int i = 0; i < NCH; i++) hi[i] = 0;
    nt = 0;
  endtask

  task automatic window(input int n);
    for (int k = 0; k < n; k++) begin
      cyc();
      for (int i = 0; i < NCH; i++) hi[i] += int'(out[i]);
      nt += int'(period_tick);
    end
  endtask

  task automatic write_duty(input int ch, input int val);
    duty_wr = 1'b1; duty_ch = CW'(ch); duty_val = 8'(val);
    cyc();
    duty_wr = 1'b0;
  endtask

  task automatic wait_tick(input int bound);
    int n = 0;
    do begin cyc(); n++; end while (period_tick !== 1'b1 && n < bound);
    chk("tick_wait", 32'(period_tick), 32'd1);
  endtask

  initial begin
    // Reset with all outputs enabled.
    rst = 1'b1; en_out = '1; en_pwm = '1;
    cyc(); cyc();
    chk("rst_out", 32'(out), 32'd0);
    rst = 1'b0;
    cyc();
    chk("post_rst_out", 32'(out), 32'd0);
    chk("post_rst_tick", 32'(period_tick), 32'd1);

    // Duty sweep and boundaries.
    period = 8'd9; prescale = 8'd0;
    en_out = 12'h00F; en_pwm = 12'h007;
    write_duty(0, 3); write_duty(1, 0); write_duty(2, 10);
    wait_tick(40); wait_tick(40);
    clear_win(); window(10);
    chk("ch0_duty3", 32'(hi[0]), 32'd3);
    chk("ch1_duty0", 32'(hi[1]), 32'd0);
    chk("ch2_full", 32'(hi[2]), 32'd10);
    chk("ch3_static", 32'(hi[3]), 32'd10);
    chk("ticks_per10", 32'(nt), 32'd1);

    // Double buffer: mid-period write waits for the boundary.
    wait_tick(40);
    clear_win(); window(4);
    duty_wr = 1'b1; duty_ch = 4'd0; duty_val = 8'd7;
    window(1);
    duty_wr = 1'b0;
    window(5);
    chk("dbuf_old", 32'(hi[0]), 32'd3);
    clear_win(); window(10);
    chk("dbuf_new", 32'(hi[0]), 32'd7);

    // Write landing on the wrap cycle applies to the very next period.
    clear_win(); window(9);
    duty_wr = 1'b1; duty_ch = 4'd0; duty_val = 8'd5;
    window(1);
    duty_wr = 1'b0;
    chk("wrapwr_prev", 32'(hi[0]), 32'd7);
    chk("wrapwr_tick", 32'(period_tick), 32'd1);
    clear_win(); window(10);
    chk("wrapwr_new", 32'(hi[0]), 32'd5);

    // Prescaler: 4 clk per tick, 5 ticks per period, duty 2.
    prescale = 8'd3; period = 8'd4;
    write_duty(0, 2);
    wait_tick(200); wait_tick(200);
    clear_win(); window(20);
    chk("psc_high", 32'(hi[0]), 32'd8);
    chk("psc_ticks", 32'(nt), 32'd1);
    write_duty(NCH, 1);
    wait_tick(200);
    clear_win(); window(20);
    chk("badch_high", 32'(hi[0]), 32'd8);
    chk("badch_ch1", 32'(hi[1]), 32'd0);

    // Randomized traffic against the reference model.
    for (int k = 0; k < 1500; k++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 7) == 0) en_out = NCH'($urandom);
      if ($urandom_range(0, 7) == 0) en_pwm = NCH'($urandom);
      if ($urandom_range(0, 39) == 0) period = 8'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) prescale = 8'($urandom_range(0, 3));
      duty_wr  = ($urandom_range(0, 3) == 0);
      duty_ch  = CW'($urandom_range(0, 15));
      duty_val = 8'($urandom_range(0, 17));
      cyc();
    end
    rst = 1'b0; duty_wr = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
